agu_burst_seq: RTL and testbench

Burst address sequencer for the word-scaled address adder (`base + index*4`, with a zero flag). It accepts a burst command (base, word count) over a valid/ready handshake. It then issues the sequence `base`, `base+4`, … `base+4*(count-1)` one address per accepted beat on a second valid/ready channel, and pulses `done` when the burst completes. It sits between the control path that requests block transfers and the memory-side consumer of word addresses.

---
 rtl/agu_burst_seq.sv | 151 +++++++++++++++
 tb/tb_agu_burst_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/agu_burst_seq.sv
// Burst address sequencer: issues base, base+4, ... for a latched word count.
// Optional AGU_SEQ_ZERO_ABORT_EN aborts the burst (done+err) instead of issuing a zero address.
module agu_burst_seq #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_base,
    input  logic [CW-1:0] cmd_count,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic [DW-1:0] addr_out,
    output logic          addr_zero,
    output logic          addr_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] base_q, base_n;
    logic [DW-1:0] addr_q, addr_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [CW-1:0] idx_q, idx_n;
    logic [CW-1:0] idx_inc;
    logic [DW-1:0] cand;
    logic          load;
    logic          zero_q, zero_n;
    logic          last_q, last_n;
    logic          done_q, done_n;
    logic          rdy_q, rdy_n;
`ifdef AGU_SEQ_ZERO_ABORT_EN
    logic          err_q, err_n;
`endif

    always_comb begin
        state_n = state;
        base_n  = base_q;
        addr_n  = addr_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        zero_n  = zero_q;
        last_n  = last_q;
        done_n  = 1'b0;
`ifdef AGU_SEQ_ZERO_ABORT_EN
        err_n   = 1'b0;
`endif
        cand    = '0;
        load    = 1'b0;
        idx_inc = idx_q + CW'(1);

        case (state)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    base_n = cmd_base;
                    cnt_n  = cmd_count;
                    idx_n  = '0;
                    if (cmd_count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        cand   = cmd_base;
                        load   = 1'b1;
                        last_n = (cmd_count == CW'(1));
                    end
                end
            end
            ISSUE: begin
                if (addr_ready) begin
                    if (last_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        last_n  = 1'b0;
                    end else begin
                        idx_n  = idx_inc;
                        cand   = base_q + (DW'(idx_inc) << 2);
                        load   = 1'b1;
                        last_n = (idx_inc == cnt_q - CW'(1));
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Every address is vetted here before it reaches addr_out.
        if (load) begin
`ifdef AGU_SEQ_ZERO_ABORT_EN
            if (cand == '0) begin
                state_n = IDLE;
                done_n  = 1'b1;
                err_n   = 1'b1;
                last_n  = 1'b0;
            end else
`endif
            begin
                state_n = ISSUE;
                addr_n  = cand;
                zero_n  = (cand == '0);
            end
        end

        rdy_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            zero_q <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            state  <= state_n;
            base_q <= base_n;
            addr_q <= addr_n;
            cnt_q  <= cnt_n;
            idx_q  <= idx_n;
            zero_q <= zero_n;
            last_q <= last_n;
            done_q <= done_n;
            rdy_q  <= rdy_n;
        end
    end

`ifdef AGU_SEQ_ZERO_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_n;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready  = rdy_q;
    assign addr_valid = (state == ISSUE);
    assign busy       = (state == ISSUE);
    assign addr_out   = addr_q;
    assign addr_zero  = zero_q;
    assign addr_last  = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_agu_burst_seq.sv
// Directed bench for agu_burst_seq; define AGU_SEQ_ZERO_ABORT_EN to match an abort-enabled build.
module tb_agu_burst_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_base;
    logic [15:0] cmd_count;
    logic        addr_valid;
    logic        addr_ready;
    logic [31:0] addr_out;
    logic        addr_zero;
    logic        addr_last;
    logic        busy;
    logic        done;
    logic        err;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    agu_burst_seq #(.DW(32), .CW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_count  (cmd_count),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_out   (addr_out),
        .addr_zero  (addr_zero),
        .addr_last  (addr_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compact check of the beat-related outputs.
    task automatic beat(input string tag, input logic v, input logic [31:0] a,
                        input logic z, input logic l);
        check({tag, ".valid"}, {31'd0, addr_valid}, {31'd0, v});
        check({tag, ".busy"},  {31'd0, busy},       {31'd0, v});
        if (v) begin
            check({tag, ".addr"}, addr_out, a);
            check({tag, ".zero"}, {31'd0, addr_zero}, {31'd0, z});
            check({tag, ".last"}, {31'd0, addr_last}, {31'd0, l});
        end
    endtask

    task automatic flags(input string tag, input logic d, input logic e, input logic r);
        check({tag, ".done"}, {31'd0, done},      {31'd0, d});
        check({tag, ".err"},  {31'd0, err},       {31'd0, e});
        check({tag, ".rdy"},  {31'd0, cmd_ready}, {31'd0, r});
    endtask

    task automatic send(input logic [31:0] b, input logic [15:0] c);
        cmd_valid = 1'b1;
        cmd_base  = b;
        cmd_count = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_base = '0;
        cmd_count = '0;
        addr_ready = 1'b1;
        #1;
        beat("rst", 1'b0, 0, 0, 0);
        check("rst.addr", addr_out, 32'h0);
        flags("rst", 1'b0, 1'b0, 1'b0);
        tick();
        flags("rst_hold", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rel.rdy_low", {31'd0, cmd_ready}, 32'd0);
        tick();
        flags("rel", 1'b0, 1'b0, 1'b1);

        // Basic burst
        send(32'h0000_1000, 16'd3);
        beat("b0", 1'b1, 32'h1000, 1'b0, 1'b0);
        flags("b0", 1'b0, 1'b0, 1'b0);
        tick(); beat("b1", 1'b1, 32'h1004, 1'b0, 1'b0);
        tick(); beat("b2", 1'b1, 32'h1008, 1'b0, 1'b1);
        tick(); beat("bd", 1'b0, 0, 0, 0); flags("bd", 1'b1, 1'b0, 1'b1);
        tick(); flags("bd1", 1'b0, 1'b0, 1'b1);

        // Backpressure on beat 2
        send(32'h0000_1000, 16'd3);
        beat("p0", 1'b1, 32'h1000, 1'b0, 1'b0);
        tick(); beat("p1", 1'b1, 32'h1004, 1'b0, 1'b0);
        addr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); beat("p1_hold", 1'b1, 32'h1004, 1'b0, 1'b0);
            flags("p1_hold", 1'b0, 1'b0, 1'b0);
        end
        addr_ready = 1'b1;
        tick(); beat("p2", 1'b1, 32'h1008, 1'b0, 1'b1);
        tick(); beat("pd", 1'b0, 0, 0, 0); flags("pd", 1'b1, 1'b0, 1'b1);

        // Zero count
        send(32'h0000_5000, 16'd0);
        beat("z", 1'b0, 0, 0, 0); flags("z", 1'b1, 1'b0, 1'b1);
        tick(); beat("z1", 1'b0, 0, 0, 0); flags("z1", 1'b0, 1'b0, 1'b1);

        // Wrap past the top of the address space
        send(32'hFFFF_FFF8, 16'd3);
        beat("w0", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
        tick(); beat("w1", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
`ifdef AGU_SEQ_ZERO_ABORT_EN
        beat("wa", 1'b0, 0, 0, 0); flags("wa", 1'b1, 1'b1, 1'b1);
        tick(); flags("wa1", 1'b0, 1'b0, 1'b1);
`else
        beat("w2", 1'b1, 32'h0, 1'b1, 1'b1);
        tick(); beat("wd", 1'b0, 0, 0, 0); flags("wd", 1'b1, 1'b0, 1'b1);
`endif

        // Back-to-back: second command held valid through the first burst
        send(32'h0000_2000, 16'd2);
        cmd_valid = 1'b1;
        cmd_base = 32'h0000_3000;
        cmd_count = 16'd1;
        beat("k0", 1'b1, 32'h2000, 1'b0, 1'b0); flags("k0", 1'b0, 1'b0, 1'b0);
        tick(); beat("k1", 1'b1, 32'h2004, 1'b0, 1'b1);
        tick(); beat("kd", 1'b0, 0, 0, 0); flags("kd", 1'b1, 1'b0, 1'b1);
        tick(); cmd_valid = 1'b0;
        beat("k2", 1'b1, 32'h3000, 1'b0, 1'b1); flags("k2", 1'b0, 1'b0, 1'b0);
        tick(); flags("k2d", 1'b1, 1'b0, 1'b1);
        tick();

        // Reset mid-burst
        send(32'h0000_4000, 16'd5);
        beat("r0", 1'b1, 32'h4000, 1'b0, 1'b0);
        tick(); beat("r1", 1'b1, 32'h4004, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        beat("ra", 1'b0, 0, 0, 0);
        check("ra.addr", addr_out, 32'h0);
        check("ra.last", {31'd0, addr_last}, 32'd0);
        flags("ra", 1'b0, 1'b0, 1'b0);
        tick(); #2 rst = 1'b0;
        flags("rr", 1'b0, 1'b0, 1'b0);
        tick(); beat("rr1", 1'b0, 0, 0, 0); flags("rr1", 1'b0, 1'b0, 1'b1);
        tick(); flags("rr2", 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
